// File: rtl/cdb_arbiter_pkg.sv
// cdb_arbiter_pkg
//   Shared types and constants for the CDB arbiter slice.
//   - cpu_params-style constants: CDB_REQ / CDB_WIDTH defaults, FU indices,
//     ROB / PRF index widths.
//   - uop_types-style typedef: cdb_pkt_t, the writeback packet on the CDB.
//   - ptr_width(): width of a round-robin pointer over n requesters.
package cdb_arbiter_pkg;

   // cpu_params
   localparam int CDB_REQ    = 4;
   localparam int CDB_WIDTH  = 2;
   localparam int FU_INT     = 0;
   localparam int FU_INTM    = 1;
   localparam int FU_BR      = 2;
   localparam int FU_MEM     = 3;
   localparam int ROB_IDX_W  = 5;
   localparam int PRF_IDX_W  = 6;
   localparam int ARCH_IDX_W = 5;
   localparam int XLEN       = 32;

   // uop_types
   typedef struct packed {
      logic [ROB_IDX_W-1:0]  rob_id;
      logic [PRF_IDX_W-1:0]  rd_phy;
      logic [ARCH_IDX_W-1:0] rd_arch;
      logic [XLEN-1:0]       rd_value;
   } cdb_pkt_t;

   // A single requester still needs a 1-bit pointer so the port is legal.
   function automatic int ptr_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/cdb_arbiter_rr_picker.sv
// cdb_rr_picker
//   Combinational round-robin picker. Scans req circularly starting at
//   rr_ptr and selects the first NUM_PORT set bits; the j-th hit goes to
//   port j.
//   Ports:
//     req        in   [NUM_REQ]            pending requests
//     rr_ptr     in   [PTR_W]              scan start index
//     port_grant out  [NUM_PORT][NUM_REQ]  one-hot requester per port
//     port_valid out  [NUM_PORT]           port j has a grant (low ports fill first)
//     last_idx   out  [PTR_W]              index of the last granted requester
module cdb_rr_picker
   import cdb_arbiter_pkg::*;
#(
   parameter int NUM_REQ  = CDB_REQ,
   parameter int NUM_PORT = CDB_WIDTH,
   parameter int PTR_W    = ptr_width(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0]  req,
   input  logic [PTR_W-1:0]    rr_ptr,
   output logic [NUM_REQ-1:0]  port_grant [NUM_PORT],
   output logic [NUM_PORT-1:0] port_valid,
   output logic [PTR_W-1:0]    last_idx
);

   always_comb begin
      int cnt;
      int idx;
      for (int k = 0; k < NUM_PORT; k++) begin
         port_grant[k] = '0;
      end
      port_valid = '0;
      last_idx   = '0;
      cnt        = 0;
      idx        = 0;
      for (int off = 0; off < NUM_REQ; off++) begin
         idx = (int'(rr_ptr) + off) % NUM_REQ;
         if (req[idx] && (cnt < NUM_PORT)) begin
            port_grant[cnt][idx] = 1'b1;
            port_valid[cnt]      = 1'b1;
            last_idx             = PTR_W'(idx);
            cnt                  = cnt + 1;
         end
      end
   end

endmodule

// File: rtl/cdb_arbiter.sv
// cdb_arbiter
//   Shares NUM_PORT CDB broadcast ports among NUM_REQ functional units.
//   Each cycle up to NUM_PORT pending packets are granted round-robin and
//   registered onto the CDB, one cycle after the grant.
//   Ports:
//     clk, rst   in   clock, asynchronous active-high reset
//     flush      in   kills in-flight broadcasts, blocks grants this cycle
//     req_valid  in   [NUM_REQ]   requester i holds a packet
//     req_pkt    in   [NUM_REQ]   requester packets
//     req_ready  out  [NUM_REQ]   requester i granted this cycle (comb.)
//     cdb_valid  out  [NUM_PORT]  port k broadcasting (registered)
//     cdb_pkt    out  [NUM_PORT]  packet on port k (registered)
//
//   Handshake: a packet moves from requester i when req_valid[i] and
//   req_ready[i] are both high at a rising edge; the requester holds valid
//   and packet stable until then. req_ready depends only on req_valid,
//   rr_ptr, flush and rst, never on req_pkt. The CDB side has no
//   backpressure: every broadcast is consumed in the cycle it is shown.
module cdb_arbiter
   import cdb_arbiter_pkg::*;
#(
   parameter int NUM_REQ  = CDB_REQ,
   parameter int NUM_PORT = CDB_WIDTH
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                flush,
   input  logic [NUM_REQ-1:0]  req_valid,
   input  cdb_pkt_t            req_pkt   [NUM_REQ],
   output logic [NUM_REQ-1:0]  req_ready,
   output logic [NUM_PORT-1:0] cdb_valid,
   output cdb_pkt_t            cdb_pkt   [NUM_PORT]
);

   localparam int PTR_W = ptr_width(NUM_REQ);

   logic [PTR_W-1:0]    rr_ptr;
   logic [PTR_W-1:0]    rr_ptr_nxt;
   logic [PTR_W-1:0]    last_idx;
   logic [NUM_REQ-1:0]  port_grant [NUM_PORT];
   logic [NUM_PORT-1:0] port_valid;
   cdb_pkt_t            pkt_nxt    [NUM_PORT];

   cdb_rr_picker #(
      .NUM_REQ  (NUM_REQ),
      .NUM_PORT (NUM_PORT),
      .PTR_W    (PTR_W)
   ) u_picker (
      .req        (req_valid),
      .rr_ptr     (rr_ptr),
      .port_grant (port_grant),
      .port_valid (port_valid),
      .last_idx   (last_idx)
   );

   // Grants are hidden while flushing or in reset so no transfer is implied
   // on an edge that will not load the CDB.
   always_comb begin
      req_ready = '0;
      for (int k = 0; k < NUM_PORT; k++) begin
         req_ready = req_ready | port_grant[k];
      end
      if (flush || rst) begin
         req_ready = '0;
      end
   end

   // One-hot AND-OR mux of the granted packet onto each port.
   always_comb begin
      for (int k = 0; k < NUM_PORT; k++) begin
         pkt_nxt[k] = '0;
         for (int i = 0; i < NUM_REQ; i++) begin
            if (port_grant[k][i]) begin
               pkt_nxt[k] = pkt_nxt[k] | req_pkt[i];
            end
         end
      end
   end

   assign rr_ptr_nxt = (last_idx == PTR_W'(NUM_REQ - 1)) ? '0 : last_idx + PTR_W'(1);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rr_ptr    <= '0;
         cdb_valid <= '0;
         for (int k = 0; k < NUM_PORT; k++) begin
            cdb_pkt[k] <= '0;
         end
      end else begin
         cdb_valid <= flush ? '0 : port_valid;
         for (int k = 0; k < NUM_PORT; k++) begin
            cdb_pkt[k] <= pkt_nxt[k];
         end
         // port_valid[0] is set whenever anything was granted.
         if (!flush && port_valid[0]) begin
            rr_ptr <= rr_ptr_nxt;
         end
      end
   end

endmodule

// File: tb/tb_cdb_arbiter.sv
module tb_cdb_arbiter;
   import cdb_arbiter_pkg::*;

   localparam int NR = 4;
   localparam int NP = 2;
   localparam int PW = $bits(cdb_pkt_t);

   logic           clk;
   logic           rst;
   logic           flush;
   logic [NR-1:0]  req_valid;
   cdb_pkt_t       req_pkt   [NR];
   logic [NR-1:0]  req_ready;
   logic [NP-1:0]  cdb_valid;
   cdb_pkt_t       cdb_pkt   [NP];

   int n_cmp;
   int n_fail;
   logic [PW-1:0] exp_q [$];

   cdb_arbiter #(.NUM_REQ(NR), .NUM_PORT(NP)) dut (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .req_valid (req_valid),
      .req_pkt   (req_pkt),
      .req_ready (req_ready),
      .cdb_valid (cdb_valid),
      .cdb_pkt   (cdb_pkt)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic cdb_pkt_t mk(input int rob, input logic [31:0] val);
      cdb_pkt_t p;
      p.rob_id   = ROB_IDX_W'(rob);
      p.rd_phy   = PRF_IDX_W'(rob + 8);
      p.rd_arch  = ARCH_IDX_W'(rob);
      p.rd_value = val;
      return p;
   endfunction

   // driver tasks
   task automatic drive_idle();
      flush     = 1'b0;
      req_valid = '0;
      for (int i = 0; i < NR; i++) req_pkt[i] = '0;
   endtask

   task automatic do_reset();
      drive_idle();
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic advance();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      drive_idle();
      rst = 1'b1;
      req_valid = 4'b1111;
      #1;
      n_cmp++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_ready got=%b exp=0000", req_ready); end
      n_cmp++; if (cdb_valid !== 2'b00) begin n_fail++; $display("FAIL reset_cdb_valid got=%b exp=00", cdb_valid); end
      n_cmp++; if (cdb_pkt[0] !== '0) begin n_fail++; $display("FAIL reset_cdb_pkt got=%h exp=0", cdb_pkt[0]); end
      advance();
      rst = 1'b0;
      for (int i = 0; i < NR; i++) req_pkt[i] = mk(i, 32'hA000 + i);
      #1;
      n_cmp++; if (req_ready !== 4'b0011) begin n_fail++; $display("FAIL reset_first_ready got=%b exp=0011", req_ready); end
      advance();
      n_cmp++; if (cdb_valid !== 2'b11) begin n_fail++; $display("FAIL pre_reset_cdb got=%b exp=11", cdb_valid); end
      // mid-cycle asynchronous reset with broadcasts in flight
      #2;
      rst = 1'b1;
      #1;
      n_cmp++; if (cdb_valid !== 2'b00) begin n_fail++; $display("FAIL async_reset_valid got=%b exp=00", cdb_valid); end
      n_cmp++; if (cdb_pkt[1] !== '0) begin n_fail++; $display("FAIL async_reset_pkt got=%h exp=0", cdb_pkt[1]); end
      #1;
      rst = 1'b0;
      #1;
      // pointer back to 0 (it was at 2 before reset)
      n_cmp++; if (req_ready !== 4'b0011) begin n_fail++; $display("FAIL post_reset_ready got=%b exp=0011", req_ready); end
      advance();
      drive_idle();
   endtask

   task automatic test_all_valid();
      do_reset();
      req_valid = 4'b1111;
      for (int i = 0; i < NR; i++) req_pkt[i] = mk(i, 32'h1000 + i);
      #1;
      n_cmp++; if (req_ready !== 4'b0011) begin n_fail++; $display("FAIL all_c0_ready got=%b exp=0011", req_ready); end
      advance();
      n_cmp++; if (cdb_valid !== 2'b11) begin n_fail++; $display("FAIL all_c0_valid got=%b exp=11", cdb_valid); end
      n_cmp++; if (cdb_pkt[0] !== mk(0, 32'h1000)) begin n_fail++; $display("FAIL all_c0_port0 got=%h exp=%h", cdb_pkt[0], mk(0, 32'h1000)); end
      n_cmp++; if (cdb_pkt[1] !== mk(1, 32'h1001)) begin n_fail++; $display("FAIL all_c0_port1 got=%h exp=%h", cdb_pkt[1], mk(1, 32'h1001)); end
      req_valid = 4'b1100;
      #1;
      n_cmp++; if (req_ready !== 4'b1100) begin n_fail++; $display("FAIL all_c1_ready got=%b exp=1100", req_ready); end
      advance();
      n_cmp++; if (cdb_pkt[0] !== mk(2, 32'h1002)) begin n_fail++; $display("FAIL all_c1_port0 got=%h exp=%h", cdb_pkt[0], mk(2, 32'h1002)); end
      n_cmp++; if (cdb_pkt[1] !== mk(3, 32'h1003)) begin n_fail++; $display("FAIL all_c1_port1 got=%h exp=%h", cdb_pkt[1], mk(3, 32'h1003)); end
      req_valid = 4'b1111;
      #1;
      n_cmp++; if (req_ready !== 4'b0011) begin n_fail++; $display("FAIL all_ptr_wrap got=%b exp=0011", req_ready); end
      req_valid = '0;
      advance();
      n_cmp++; if (cdb_valid !== 2'b00) begin n_fail++; $display("FAIL all_idle_valid got=%b exp=00", cdb_valid); end
   endtask

   task automatic test_single_req();
      do_reset();
      req_valid = 4'b0001;
      req_pkt[0] = mk(0, 32'h2000);
      advance();                         // rr_ptr -> 1
      req_valid = 4'b1000;
      req_pkt[3] = mk(3, 32'h2003);
      #1;
      n_cmp++; if (req_ready !== 4'b1000) begin n_fail++; $display("FAIL single_ready got=%b exp=1000", req_ready); end
      advance();                         // rr_ptr -> 0
      n_cmp++; if (cdb_valid !== 2'b01) begin n_fail++; $display("FAIL single_valid got=%b exp=01", cdb_valid); end
      n_cmp++; if (cdb_pkt[0] !== mk(3, 32'h2003)) begin n_fail++; $display("FAIL single_port0 got=%h exp=%h", cdb_pkt[0], mk(3, 32'h2003)); end
      req_valid = 4'b1001;
      req_pkt[0] = mk(0, 32'h2010);
      req_pkt[3] = mk(3, 32'h2013);
      #1;
      n_cmp++; if (req_ready !== 4'b1001) begin n_fail++; $display("FAIL pair_ready got=%b exp=1001", req_ready); end
      advance();                         // rr_ptr -> 0
      n_cmp++; if (cdb_pkt[0] !== mk(0, 32'h2010)) begin n_fail++; $display("FAIL pair_port0 got=%h exp=%h", cdb_pkt[0], mk(0, 32'h2010)); end
      n_cmp++; if (cdb_pkt[1] !== mk(3, 32'h2013)) begin n_fail++; $display("FAIL pair_port1 got=%h exp=%h", cdb_pkt[1], mk(3, 32'h2013)); end
      req_valid = 4'b1111;
      #1;
      n_cmp++; if (req_ready !== 4'b0011) begin n_fail++; $display("FAIL pair_ptr got=%b exp=0011", req_ready); end
      drive_idle();
      advance();
   endtask

   task automatic test_wraparound();
      do_reset();
      req_valid = 4'b0100;
      req_pkt[2] = mk(2, 32'h3002);
      advance();                         // rr_ptr -> 3
      req_valid = 4'b1101;
      req_pkt[0] = mk(0, 32'h3100);
      req_pkt[2] = mk(2, 32'h3102);
      req_pkt[3] = mk(3, 32'h3103);
      #1;
      n_cmp++; if (req_ready !== 4'b1001) begin n_fail++; $display("FAIL wrap_ready got=%b exp=1001", req_ready); end
      advance();                         // rr_ptr -> 1
      n_cmp++; if (cdb_pkt[0] !== mk(3, 32'h3103)) begin n_fail++; $display("FAIL wrap_port0 got=%h exp=%h", cdb_pkt[0], mk(3, 32'h3103)); end
      n_cmp++; if (cdb_pkt[1] !== mk(0, 32'h3100)) begin n_fail++; $display("FAIL wrap_port1 got=%h exp=%h", cdb_pkt[1], mk(0, 32'h3100)); end
      req_pkt[0] = mk(0, 32'h3200);
      req_pkt[3] = mk(3, 32'h3203);
      #1;
      n_cmp++; if (req_ready !== 4'b1100) begin n_fail++; $display("FAIL wrap_next_ready got=%b exp=1100", req_ready); end
      advance();
      n_cmp++; if (cdb_pkt[0] !== mk(2, 32'h3102)) begin n_fail++; $display("FAIL wrap_next_port0 got=%h exp=%h", cdb_pkt[0], mk(2, 32'h3102)); end
      n_cmp++; if (cdb_pkt[1] !== mk(3, 32'h3203)) begin n_fail++; $display("FAIL wrap_next_port1 got=%h exp=%h", cdb_pkt[1], mk(3, 32'h3203)); end
      drive_idle();
      advance();
   endtask

   task automatic test_flush();
      do_reset();
      req_valid = 4'b1111;
      for (int i = 0; i < NR; i++) req_pkt[i] = mk(i, 32'h4000 + i);
      advance();                         // rr_ptr -> 2, ports carry 0,1
      n_cmp++; if (cdb_valid !== 2'b11) begin n_fail++; $display("FAIL flush_pre_valid got=%b exp=11", cdb_valid); end
      req_pkt[0] = mk(0, 32'h4100);
      req_pkt[1] = mk(1, 32'h4101);
      flush = 1'b1;
      #1;
      n_cmp++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL flush_ready got=%b exp=0000", req_ready); end
      advance();
      n_cmp++; if (cdb_valid !== 2'b00) begin n_fail++; $display("FAIL flush_cdb_valid got=%b exp=00", cdb_valid); end
      flush = 1'b0;
      #1;
      n_cmp++; if (req_ready !== 4'b1100) begin n_fail++; $display("FAIL flush_resume_ready got=%b exp=1100", req_ready); end
      advance();
      n_cmp++; if (cdb_pkt[0] !== mk(2, 32'h4002)) begin n_fail++; $display("FAIL flush_resume_port0 got=%h exp=%h", cdb_pkt[0], mk(2, 32'h4002)); end
      n_cmp++; if (cdb_pkt[1] !== mk(3, 32'h4003)) begin n_fail++; $display("FAIL flush_resume_port1 got=%h exp=%h", cdb_pkt[1], mk(3, 32'h4003)); end
      drive_idle();
      advance();
   endtask

   // Random soak: requesters hold until granted; checks grant legality,
   // grant count, wait bound and exact-once delivery of every packet.
   task automatic test_soak();
      logic [NR-1:0] pend;
      logic [NR-1:0] took;
      int            waitc [NR];
      logic [31:0]   seq;
      int            exp_cnt;
      int            nv;
      bit            found;
      do_reset();
      pend = '0;
      seq  = 32'h5000;
      for (int i = 0; i < NR; i++) waitc[i] = 0;
      for (int cyc = 0; cyc < 10000; cyc++) begin
         for (int i = 0; i < NR; i++) begin
            if (!pend[i] && ($urandom_range(3, 0) != 0)) begin
               pend[i]    = 1'b1;
               req_pkt[i] = mk(i, seq);
               seq        = seq + 1;
            end
         end
         req_valid = pend;
         flush     = ($urandom_range(15, 0) == 0);
         #1;
         exp_cnt = flush ? 0 : (($countones(pend) < NP) ? $countones(pend) : NP);
         n_cmp++; if ((req_ready & ~req_valid) !== '0) begin n_fail++; $display("FAIL soak_grant_invalid cyc=%0d ready=%b valid=%b", cyc, req_ready, req_valid); end
         n_cmp++; if ($countones(req_ready) != exp_cnt) begin n_fail++; $display("FAIL soak_grant_count cyc=%0d got=%0d exp=%0d", cyc, $countones(req_ready), exp_cnt); end
         took = req_ready & pend;
         for (int i = 0; i < NR; i++) begin
            if (took[i]) begin
               exp_q.push_back(req_pkt[i]);
               waitc[i] = 0;
            end else if (pend[i] && !flush) begin
               waitc[i]++;
               n_cmp++; if (waitc[i] >= 2) begin n_fail++; $display("FAIL soak_starve cyc=%0d req=%0d waited=%0d exp<2", cyc, i, waitc[i]); end
            end
         end
         advance();
         nv = $countones(cdb_valid);
         n_cmp++; if (nv != exp_q.size()) begin n_fail++; $display("FAIL soak_port_count cyc=%0d got=%0d exp=%0d", cyc, nv, exp_q.size()); end
         n_cmp++; if (cdb_valid === 2'b10) begin n_fail++; $display("FAIL soak_port_order cyc=%0d got=%b exp=low-first", cyc, cdb_valid); end
         for (int k = 0; k < NP; k++) begin
            if (cdb_valid[k]) begin
               found = 1'b0;
               for (int e = 0; e < exp_q.size(); e++) begin
                  if (!found && exp_q[e] === cdb_pkt[k]) begin
                     exp_q.delete(e);
                     found = 1'b1;
                  end
               end
               n_cmp++; if (!found) begin n_fail++; $display("FAIL soak_pkt cyc=%0d port=%0d got=%h exp=granted-packet", cyc, k, cdb_pkt[k]); end
            end
         end
         n_cmp++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL soak_lost cyc=%0d left=%0d exp=0", cyc, exp_q.size()); end
         exp_q.delete();
         pend = pend & ~took;
      end
      drive_idle();
      advance();
   endtask

   initial begin
      n_cmp  = 0;
      n_fail = 0;
      rst    = 1'b1;
      drive_idle();
      test_reset();
      test_all_valid();
      test_single_req();
      test_wraparound();
      test_flush();
      test_soak();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
